mmio_switch_port: RTL and testbench
===================================

# mmio_switch_port

Memory-mapped I/O responder on the MEM-stage data bus of the pipelined CPU. It answers the load/store requests the CPU initiates: it serves synchronized and debounced switch values, plus a change-event status and counter, on reads. It accepts stores into two display registers that feed the seven-segment driver. It replaces direct taps of data-memory words for display and direct switch wiring into decode.

## Interface
- `SW_W`, 13: switch bus width.
- `DEB_CYCLES`, 50000: cycles a synchronized switch value must stay stable before it is accepted (minimum 2).
- `CNT_W`, 16: event counter width.

- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `sw`, in, `SW_W`: raw board switches, asynchronous to `clk`.
- `sel`, in, 1: CPU access targets this block (address decode done upstream).
- `rd`, in, 1: load strobe, qualified by `sel`.
- `wr`, in, 1: store strobe, qualified by `sel`.
- `addr`, in, 3: word index of the register.
- `wdata`, in, 32: store data.
- `rdata`, out, 32: registered load data.
- `rvalid`, out, 1: one-cycle pulse, `rdata` updated.
- `disp_a`, out, 32: display register A (the "bigger" value).
- `disp_b`, out, 32: display register B (the "smaller" value).
- `irq`, out, 1: change interrupt (see Configuration).

## Operation
- Synchronizer: two-flop chain on `sw` gives `sw_sync`. Its reset value is 0.
- Debouncer:
  - A counter `dcnt` tracks how long `sw_sync` has differed from the accepted value `sw_deb`.
  - `sw_sync != sw_deb`: `dcnt` increments. When `dcnt == DEB_CYCLES-1`, the next edge loads `sw_deb <= sw_sync`, clears `dcnt`, sets `pend` and increments `evcnt`.
  - `sw_sync == sw_deb`: `dcnt` clears.
  - If `sw_sync` changes to a third value mid-count, the count continues; acceptance samples `sw_sync` at terminal count.
- `evcnt` wraps modulo 2^`CNT_W`.
- Register map. Reads are zero-extended. Unmapped reads return 0 and unmapped writes are ignored.
  - 0 `SW_RAW` (RO): `sw_sync`.
  - 1 `SW_DEB` (RO): `sw_deb`.
  - 2 `STATUS`: bit0 `pend` (write 1 clears), bit1 `stable` (RO, `dcnt==0`), bit2 `ie` (RW, interrupt enable).
  - 3 `DISP_A` (RW).
  - 4 `DISP_B` (RW).
  - 5 `EVCNT` (RO). Any write clears it to 0.
- Write accepted when `sel && wr`; takes effect at the clock edge.
- Set/clear priority:
  - If a debounce acceptance and a `pend` clear land on the same edge, set wins and `pend` stays 1.
  - If acceptance and an `EVCNT` clear coincide, `evcnt` becomes 1.
- `sel && rd && wr` in the same cycle: the write is performed, and `rdata` returns the pre-write value.
- `rd` or `wr` without `sel`: ignored.

## Timing
- Load latency is 1 cycle. A read issued at edge N has `rdata`/`rvalid` valid after edge N+1, aligned with the MEM/WB register.
- `rdata` holds its value until the next read. `rvalid` is high exactly one cycle per read.
- `disp_a`/`disp_b` are register outputs and change on the edge after a write.
- Switch-to-`SW_DEB` latency for a clean step is 2 sync cycles + `DEB_CYCLES` cycles.
- `pend` is visible in `STATUS` on the read issued after the acceptance edge.
- Reset values: `rdata`=0, `rvalid`=0, `disp_a`=0, `disp_b`=0, `irq`=0. Internal: `sw_sync`=0, `sw_deb`=0, `dcnt`=0, `pend`=0, `ie`=0, `evcnt`=0.
- Reset asserted mid-count or mid-read: all state returns to reset values immediately. No `rvalid` is produced for a read in flight.

## Configuration
- Macro: `MMIO_SWITCH_IRQ_EN`.
- Defined: `irq` is registered `pend && ie`. It rises the edge after `pend` sets (with `ie`=1) and falls the edge after `pend` clears or `ie` is written 0.
- Undefined: `irq` is tied to 0. `STATUS` bit2 reads 0 and writes to it are ignored. All other behaviour is unchanged.

## Test plan
Bench uses `DEB_CYCLES`=4.
- Reset: hold `rst`=0, drive `sw`=13'h1FFF, release, read addr 1 → `rdata`=0 on the first read issued after release. Also check `disp_a`=`disp_b`=0.
- Clean step: `sw` 0→13'h0A5, wait 7 cycles, read addr 1 → 32'h0A5. Read addr 2 → bit0=1. Read addr 5 → 1.
- Bounce: toggle `sw` between 13'h001 and 0 every 2 cycles for 20 cycles, then hold 0 → `SW_DEB` stays 0 and `EVCNT` stays 0.
- Display stores: write 32'd42 to addr 3 and 32'd7 to addr 4 → `disp_a`=42 and `disp_b`=7 on the next edge. Read addr 3 → 42 with a 1-cycle `rvalid` pulse.
- Collision: a write of 32'h1 to addr 2 on the same edge as a debounce acceptance → `pend` reads 1. Read and write to addr 3 in the same cycle → `rdata` returns the old value, and the new value appears on `disp_a`.
- IRQ (macro defined): write 32'h4 to addr 2, produce a switch change → `irq`=1 one edge after `pend`. Write 32'h5 → `irq`=0 next edge. With the macro undefined, the same sequence leaves `irq`=0.

Source files
------------

// File: rtl/mmio_switch_port.sv
// mmio_switch_port: MEM-stage MMIO responder serving debounced switches, change events and two display registers
//   Optional feature macro: MMIO_SWITCH_IRQ_EN (defines the interrupt enable bit and a registered irq)
//   Ports:
//     clk, rst (async, active-low)  clock and reset
//     sw      [SW_W-1:0]  raw board switches, asynchronous to clk
//     sel, rd, wr         CPU access select, load strobe, store strobe
//     addr    [2:0]       register word index
//     wdata   [31:0]      store data
//     rdata   [31:0]      registered load data (held until the next load)
//     rvalid              one-cycle pulse per load
//     disp_a, disp_b      display registers for the seven-segment driver
//     irq                 change interrupt (pend && ie, 0 without MMIO_SWITCH_IRQ_EN)
module mmio_switch_port #(
    parameter int SW_W       = 13,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw,
    input  logic            sel,
    input  logic            rd,
    input  logic            wr,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            rvalid,
    output logic [31:0]     disp_a,
    output logic [31:0]     disp_b,
    output logic            irq
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DTERM = DW'(DEB_CYCLES - 1);
    logic [SW_W-1:0]  sw_meta, sw_sync, sw_deb;
    logic [DW-1:0]    dcnt;
    logic [CNT_W-1:0] evcnt;
    logic             pend, ie, acc, we, re, pend_clr, ev_clr;
    logic [31:0]      rmux;
    always_comb begin
        we       = sel && wr;
        re       = sel && rd;
        acc      = (sw_sync != sw_deb) && (dcnt == DTERM);
        pend_clr = we && addr == 3'd2 && wdata[0];
        ev_clr   = we && addr == 3'd5;
        rmux     = addr == 3'd0 ? 32'(sw_sync) :
                   addr == 3'd1 ? 32'(sw_deb) :
                   addr == 3'd2 ? {29'd0, ie, dcnt == '0, pend} :
                   addr == 3'd3 ? disp_a :
                   addr == 3'd4 ? disp_b :
                   addr == 3'd5 ? 32'(evcnt) : 32'd0;
    end
    // Acceptance samples whatever sw_sync holds at terminal count; a set of
    // pend or an evcnt increment beats a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_deb  <= '0;
            dcnt    <= '0;
            pend    <= 1'b0;
            evcnt   <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            dcnt    <= (sw_sync == sw_deb || acc) ? '0 : dcnt + DW'(1);
            sw_deb  <= acc ? sw_sync : sw_deb;
            pend    <= acc | (pend & ~pend_clr);
            evcnt   <= (ev_clr ? '0 : evcnt) + CNT_W'(acc);
        end
    end
    // rmux reflects pre-write state, so a combined load/store returns the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            disp_a <= '0;
            disp_b <= '0;
        end else begin
            rvalid <= re;
            rdata  <= re ? rmux : rdata;
            disp_a <= (we && addr == 3'd3) ? wdata : disp_a;
            disp_b <= (we && addr == 3'd4) ? wdata : disp_b;
        end
    end
`ifdef MMIO_SWITCH_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            ie  <= (we && addr == 3'd2) ? wdata[2] : ie;
            irq <= pend && ie;
        end
    end
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_switch_port.sv
// tb_mmio_switch_port: directed and randomized checks of mmio_switch_port against a behavioural model
module tb_mmio_switch_port;
    localparam int SW_W = 13;
    localparam int DEB  = 4;
    localparam int CNT_W = 16;
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [SW_W-1:0] sw = '0;
    logic            sel = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [2:0]      addr = '0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata, disp_a, disp_b;
    logic            rvalid, irq;
    int n_chk = 0;
    int n_fail = 0;
    mmio_switch_port #(.SW_W(SW_W), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sw(sw), .sel(sel), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .disp_a(disp_a), .disp_b(disp_b), .irq(irq)
    );
    always #5 clk = ~clk;
`ifdef MMIO_SWITCH_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    // Behavioural model: a two-stage delay line feeding a "how long has it differed" timer.
    logic [SW_W-1:0]  m_s1, m_sync, m_deb;
    int               m_run;
    logic             m_pend, m_ie, m_rvalid, m_irq;
    logic [CNT_W-1:0] m_ev;
    logic [31:0]      m_da, m_db, m_rdata;
    function automatic logic [31:0] mread(input logic [2:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a == 3'd0) v = 32'(m_sync);
        if (a == 3'd1) v = 32'(m_deb);
        if (a == 3'd2) v = {29'd0, m_ie, m_run == 0, m_pend};
        if (a == 3'd3) v = m_da;
        if (a == 3'd4) v = m_db;
        if (a == 3'd5) v = 32'(m_ev);
        return v;
    endfunction
    task automatic m_reset();
        m_s1 = '0; m_sync = '0; m_deb = '0; m_run = 0; m_pend = 0; m_ie = 0;
        m_rvalid = 0; m_irq = 0; m_ev = '0; m_da = '0; m_db = '0; m_rdata = '0;
    endtask
    task automatic cyc();
        logic accept, we, re;
        logic [SW_W-1:0] n_s1, n_sync, n_deb;
        int n_run;
        logic n_pend, n_ie, n_rvalid, n_irq;
        logic [CNT_W-1:0] n_ev;
        logic [31:0] n_da, n_db, n_rdata;
        we = sel && wr;
        re = sel && rd;
        accept = (m_sync != m_deb) && (m_run == DEB - 1);
        n_run = (m_sync == m_deb || accept) ? 0 : m_run + 1;
        n_deb = accept ? m_sync : m_deb;
        n_s1 = sw;
        n_sync = m_s1;
        n_pend = accept ? 1'b1 : (we && addr == 3'd2 && wdata[0]) ? 1'b0 : m_pend;
        n_ie = (IRQ_ON && we && addr == 3'd2) ? wdata[2] : m_ie;
        n_irq = IRQ_ON && m_pend && m_ie;
        n_ev = (we && addr == 3'd5) ? CNT_W'(accept) : m_ev + CNT_W'(accept);
        n_da = (we && addr == 3'd3) ? wdata : m_da;
        n_db = (we && addr == 3'd4) ? wdata : m_db;
        n_rdata = re ? mread(addr) : m_rdata;
        n_rvalid = re;
        @(posedge clk);
        #1;
        m_s1 = n_s1; m_sync = n_sync; m_deb = n_deb; m_run = n_run; m_pend = n_pend;
        m_ie = n_ie; m_irq = n_irq; m_ev = n_ev; m_da = n_da; m_db = n_db;
        m_rdata = n_rdata; m_rvalid = n_rvalid;
    endtask
    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        sel = 1; wr = 1; addr = a; wdata = d;
        cyc();
        sel = 0; wr = 0;
    endtask
    task automatic rd_reg(input logic [2:0] a, output logic [31:0] v, output logic pv);
        sel = 1; rd = 1; addr = a;
        cyc();
        v = rdata; pv = rvalid;
        sel = 0; rd = 0;
    endtask
    task automatic test_reset();
        logic [31:0] v;
        logic pv;
        rst = 0; sw = 13'h1FFF;
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        n_chk++; if (rdata !== 32'd0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rd: rdata=%h rvalid=%b want 0/0", rdata, rvalid); end
        n_chk++; if (disp_a !== 32'd0 || disp_b !== 32'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_out: a=%h b=%h irq=%b want 0", disp_a, disp_b, irq); end
        rst = 1;
        rd_reg(3'd1, v, pv);
        n_chk++; if (v !== 32'd0 || pv !== 1'b1) begin n_fail++; $display("FAIL reset_swdeb: got %h/%b want 0/1", v, pv); end
        sw = 0;
        repeat (8) cyc();
    endtask
    task automatic test_clean_step();
        logic [31:0] v;
        logic pv;
        sw = 13'h0A5;
        repeat (7) cyc();
        rd_reg(3'd1, v, pv);
        n_chk++; if (v !== 32'h0A5) begin n_fail++; $display("FAIL step_deb: got %h want 0a5", v); end
        rd_reg(3'd2, v, pv);
        n_chk++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL step_pend: got %h want bit0=1", v); end
        rd_reg(3'd5, v, pv);
        n_chk++; if (v !== 32'd1) begin n_fail++; $display("FAIL step_evcnt: got %h want 1", v); end
    endtask
    task automatic test_bounce();
        logic [31:0] v;
        logic pv;
        sw = 0;
        repeat (10) cyc();
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd2, 32'd1);
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 13'h001 : 13'h000;
            cyc();
            cyc();
        end
        sw = 0;
        repeat (8) cyc();
        rd_reg(3'd1, v, pv);
        n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL bounce_deb: got %h want 0", v); end
        rd_reg(3'd5, v, pv);
        n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL bounce_evcnt: got %h want 0", v); end
        rd_reg(3'd2, v, pv);
        n_chk++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL bounce_pend: got %h want bit0=0", v); end
    endtask
    task automatic test_display();
        logic [31:0] v;
        logic pv;
        wr_reg(3'd3, 32'd42);
        n_chk++; if (disp_a !== 32'd42) begin n_fail++; $display("FAIL disp_a: got %0d want 42", disp_a); end
        wr_reg(3'd4, 32'd7);
        n_chk++; if (disp_b !== 32'd7) begin n_fail++; $display("FAIL disp_b: got %0d want 7", disp_b); end
        rd_reg(3'd3, v, pv);
        n_chk++; if (v !== 32'd42 || pv !== 1'b1) begin n_fail++; $display("FAIL disp_read: got %0d/%b want 42/1", v, pv); end
        cyc();
        n_chk++; if (rvalid !== 1'b0 || rdata !== 32'd42) begin n_fail++; $display("FAIL rvalid_pulse: got %b/%0d want 0/42", rvalid, rdata); end
    endtask
    task automatic test_collision();
        logic [31:0] v;
        logic pv;
        sw = 13'h003;
        repeat (5) cyc();
        wr_reg(3'd2, 32'h1);
        rd_reg(3'd1, v, pv);
        n_chk++; if (v !== 32'h3) begin n_fail++; $display("FAIL coll_deb: got %h want 3", v); end
        rd_reg(3'd2, v, pv);
        n_chk++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL coll_pend: got %h want bit0=1", v); end
        sw = 13'h000;
        repeat (5) cyc();
        wr_reg(3'd5, 32'hFFFF);
        rd_reg(3'd5, v, pv);
        n_chk++; if (v !== 32'd1) begin n_fail++; $display("FAIL coll_evcnt: got %h want 1", v); end
        sel = 1; rd = 1; wr = 1; addr = 3'd3; wdata = 32'd99;
        cyc();
        sel = 0; rd = 0; wr = 0;
        n_chk++; if (rdata !== 32'd42 || rvalid !== 1'b1) begin n_fail++; $display("FAIL rw_old: got %0d/%b want 42/1", rdata, rvalid); end
        n_chk++; if (disp_a !== 32'd99) begin n_fail++; $display("FAIL rw_new: got %0d want 99", disp_a); end
    endtask
    task automatic test_irq();
        logic [31:0] v;
        logic pv;
        wr_reg(3'd2, 32'h1);
        wr_reg(3'd2, 32'h4);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b want 0", irq); end
        sw = 13'h010;
        repeat (6) cyc();
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_at_accept: got %b want 0", irq); end
        cyc();
        n_chk++; if (irq !== IRQ_ON) begin n_fail++; $display("FAIL irq_rise: got %b want %b", irq, IRQ_ON); end
        wr_reg(3'd2, 32'h5);
        n_chk++; if (irq !== IRQ_ON) begin n_fail++; $display("FAIL irq_hold: got %b want %b", irq, IRQ_ON); end
        cyc();
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", irq); end
        rd_reg(3'd2, v, pv);
        n_chk++; if (v !== (IRQ_ON ? 32'h6 : 32'h2)) begin n_fail++; $display("FAIL irq_status: got %h want %h", v, IRQ_ON ? 32'h6 : 32'h2); end
    endtask
    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0) sw = ($urandom_range(1) == 0) ? SW_W'($urandom_range(7)) : SW_W'($urandom);
            sel = ($urandom_range(3) != 0);
            rd = $urandom_range(1);
            wr = ($urandom_range(3) == 0);
            addr = 3'($urandom_range(7));
            wdata = $urandom;
            cyc();
            n_chk++; if (rdata !== m_rdata || rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_read @%0d: got %h/%b want %h/%b", i, rdata, rvalid, m_rdata, m_rvalid); end
            n_chk++; if (disp_a !== m_da || disp_b !== m_db) begin n_fail++; $display("FAIL rnd_disp @%0d: got %h/%h want %h/%h", i, disp_a, disp_b, m_da, m_db); end
            n_chk++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq @%0d: got %b want %b", i, irq, m_irq); end
        end
        sel = 0; rd = 0; wr = 0;
    endtask
    task automatic test_reset_mid();
        logic [31:0] v;
        logic pv;
        wr_reg(3'd3, 32'h1234);
        sw = 13'h1FFF;
        repeat (4) cyc();
        sel = 1; rd = 1; addr = 3'd3;
        #3;
        rst = 0;
        #1;
        n_chk++; if (rdata !== 32'd0 || rvalid !== 1'b0 || disp_a !== 32'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL midreset_async: rdata=%h rvalid=%b a=%h irq=%b want 0", rdata, rvalid, disp_a, irq); end
        sel = 0; rd = 0;
        m_reset();
        @(posedge clk);
        #1;
        n_chk++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_rvalid: got %b want 0", rvalid); end
        rst = 1;
        rd_reg(3'd1, v, pv);
        n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_deb: got %h want 0", v); end
        rd_reg(3'd5, v, pv);
        n_chk++; if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_evcnt: got %h want 0", v); end
    endtask
    initial begin
        m_reset();
        test_reset();
        test_clean_step();
        test_bounce();
        test_display();
        test_collision();
        test_irq();
        test_random();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
